keypad_emulator: RTL and testbench



---
 rtl/keypad_emulator.sv | 195 +++++++++++++++++++
 tb/tb_keypad_emulator.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/keypad_emulator.sv
// Emulated 4x4 matrix keypad: replays key-press commands onto the column
// lines of a row-driven scanner, with LFSR-generated contact bounce.
module keypad_emulator #(
  parameter int unsigned BOUNCE_CYCLES = 8,
  parameter int unsigned GAP_CYCLES    = 16,
  parameter logic [7:0]  LFSR_SEED     = 8'hA5
) (
  input  logic       clk,
  input  logic       inv_reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [3:0] cmd_key,
  input  logic [7:0] cmd_hold,
  input  logic       R0,
  input  logic       R1,
  input  logic       R2,
  input  logic       R3,
  output logic       C0,
  output logic       C1,
  output logic       C2,
  output logic       C3,
  output logic       contact,
  output logic       busy,
  output logic       done
);

  localparam int unsigned MAX_BG  = (BOUNCE_CYCLES > GAP_CYCLES) ? BOUNCE_CYCLES : GAP_CYCLES;
  localparam int unsigned CNT_MAX = (MAX_BG > 255) ? MAX_BG : 255;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [7:0]       SEED        = (LFSR_SEED == 8'h00) ? 8'h01 : LFSR_SEED;
  localparam logic [CNT_W-1:0] BOUNCE_LOAD = CNT_W'((BOUNCE_CYCLES == 0) ? 0 : BOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD    = CNT_W'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    PRESS_BOUNCE,
    HELD,
    RELEASE_BOUNCE,
    GAP
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] hold_q, hold_d;
  logic [7:0]       lfsr_q, lfsr_d;
  logic [3:0]       key_q, key_d;
  logic             done_q, done_d;

  logic [CNT_W-1:0] hold_load;
  logic [3:0]       rows;
  logic [3:0]       cols;
  logic [1:0]       row_sel;
  logic [1:0]       col_sel;

  // Returns {row, col} of a key code on the fixed keypad layout.
  function automatic logic [3:0] key_pos(input logic [3:0] key);
    logic [3:0] pos;
    case (key)
      4'h1:    pos = {2'd0, 2'd0};
      4'h2:    pos = {2'd0, 2'd1};
      4'h3:    pos = {2'd0, 2'd2};
      4'hA:    pos = {2'd0, 2'd3};
      4'h4:    pos = {2'd1, 2'd0};
      4'h5:    pos = {2'd1, 2'd1};
      4'h6:    pos = {2'd1, 2'd2};
      4'hB:    pos = {2'd1, 2'd3};
      4'h7:    pos = {2'd2, 2'd0};
      4'h8:    pos = {2'd2, 2'd1};
      4'h9:    pos = {2'd2, 2'd2};
      4'hC:    pos = {2'd2, 2'd3};
      4'hE:    pos = {2'd3, 2'd0};
      4'h0:    pos = {2'd3, 2'd1};
      4'hF:    pos = {2'd3, 2'd2};
      default: pos = {2'd3, 2'd3};
    endcase
    return pos;
  endfunction

  assign hold_load = (cmd_hold == 8'd0) ? '0 : CNT_W'(cmd_hold - 8'd1);

  assign lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};

  always_ff @(posedge clk or negedge inv_reset) begin
    if (!inv_reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      hold_q  <= '0;
      lfsr_q  <= SEED;
      key_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hold_q  <= hold_d;
      lfsr_q  <= lfsr_d;
      key_q   <= key_d;
      done_q  <= done_d;
    end
  end

  // Each timed state preloads its duration minus one and leaves on zero.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hold_d  = hold_q;
    key_d   = key_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          key_d  = cmd_key;
          hold_d = hold_load;
          if (BOUNCE_CYCLES == 0) begin
            state_d = HELD;
            cnt_d   = hold_load;
          end else begin
            state_d = PRESS_BOUNCE;
            cnt_d   = BOUNCE_LOAD;
          end
        end
      end
      PRESS_BOUNCE: begin
        if (cnt_q == '0) begin
          state_d = HELD;
          cnt_d   = hold_q;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      HELD: begin
        if (cnt_q == '0) begin
          if (BOUNCE_CYCLES == 0) begin
            state_d = GAP;
            cnt_d   = GAP_LOAD;
          end else begin
            state_d = RELEASE_BOUNCE;
            cnt_d   = BOUNCE_LOAD;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RELEASE_BOUNCE: begin
        if (cnt_q == '0) begin
          state_d = GAP;
          cnt_d   = GAP_LOAD;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      GAP: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    contact = 1'b0;
    case (state_q)
      PRESS_BOUNCE, RELEASE_BOUNCE: contact = lfsr_q[0];
      HELD:                         contact = 1'b1;
      default:                      contact = 1'b0;
    endcase
  end

  assign cmd_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign done      = done_q;

  // AND with contact first so undriven rows never reach the columns while idle.
  assign rows             = {R3, R2, R1, R0};
  assign {row_sel, col_sel} = key_pos(key_q);

  always_comb begin
    cols = '0;
    if (contact && rows[row_sel]) begin
      cols[col_sel] = 1'b1;
    end
  end

  assign C0 = cols[0];
  assign C1 = cols[1];
  assign C2 = cols[2];
  assign C3 = cols[3];

endmodule

// File: tb/tb_keypad_emulator.sv
// Scoreboard bench: stimulus queues per-cycle expected outputs, monitors pop on busy/done.
module tb_keypad_emulator;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  // DUT z: no bounce, short gap.  DUT d: default parameters.
  logic       val_z, rdy_z, con_z, busy_z, done_z;
  logic [3:0] key_z, rows_z, cols_z;
  logic [7:0] hold_z;
  logic       val_d, rdy_d, con_d, busy_d, done_d;
  logic [3:0] key_d, rows_d, cols_d;
  logic [7:0] hold_d;

  int checks = 0;
  int errors = 0;

  logic [7:0] q_z[$];
  logic [7:0] q_d[$];
  logic [7:0] lf_m;

  keypad_emulator #(.BOUNCE_CYCLES(0), .GAP_CYCLES(4), .LFSR_SEED(8'hA5)) u_z (
    .clk(clk), .inv_reset(rst_n), .cmd_valid(val_z), .cmd_ready(rdy_z),
    .cmd_key(key_z), .cmd_hold(hold_z),
    .R0(rows_z[0]), .R1(rows_z[1]), .R2(rows_z[2]), .R3(rows_z[3]),
    .C0(cols_z[0]), .C1(cols_z[1]), .C2(cols_z[2]), .C3(cols_z[3]),
    .contact(con_z), .busy(busy_z), .done(done_z)
  );

  keypad_emulator #(.BOUNCE_CYCLES(8), .GAP_CYCLES(16), .LFSR_SEED(8'hA5)) u_d (
    .clk(clk), .inv_reset(rst_n), .cmd_valid(val_d), .cmd_ready(rdy_d),
    .cmd_key(key_d), .cmd_hold(hold_d),
    .R0(rows_d[0]), .R1(rows_d[1]), .R2(rows_d[2]), .R3(rows_d[3]),
    .C0(cols_d[0]), .C1(cols_d[1]), .C2(cols_d[2]), .C3(cols_d[3]),
    .contact(con_d), .busy(busy_d), .done(done_d)
  );

  logic [7:0] obs_z, obs_d;
  assign obs_z = {rdy_z, busy_z, done_z, con_z, cols_z};
  assign obs_d = {rdy_d, busy_d, done_d, con_d, cols_d};

  function automatic logic [7:0] lf_step(input logic [7:0] v);
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) lf_m <= 8'hA5;
    else        lf_m <= lf_step(lf_m);
  end

  // Keypad layout read row by row.
  function automatic int key_index(input logic [3:0] key);
    logic [3:0] kmap [16];
    kmap = '{4'h1, 4'h2, 4'h3, 4'hA, 4'h4, 4'h5, 4'h6, 4'hB,
             4'h7, 4'h8, 4'h9, 4'hC, 4'hE, 4'h0, 4'hF, 4'hD};
    for (int k = 0; k < 16; k++) if (kmap[k] == key) return k;
    return 0;
  endfunction

  // Expected {ready, busy, done, contact, C[3:0]} for busy cycle i (i == n is the done cycle).
  function automatic logic [7:0] exp_rec(input int b, input int g, input logic [3:0] key,
                                         input int hold, input logic [7:0] lf,
                                         input logic [3:0] rows, input int i);
    int he, n, idx;
    logic con, bsy, dn;
    logic [3:0] c;
    he = (hold == 0) ? 1 : hold;
    n  = 2 * b + he + g;
    if (i < b)               con = lf[0];
    else if (i < b + he)     con = 1'b1;
    else if (i < 2 * b + he) con = lf[0];
    else                     con = 1'b0;
    bsy = (i < n);
    dn  = (i == n);
    idx = key_index(key);
    c   = '0;
    if (con && rows[idx / 4]) c[idx % 4] = 1'b1;
    return {~bsy, bsy, dn, con, c};
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && (busy_z || done_z)) begin
      if (q_z.size() == 0) begin
        checks++; errors++;
        $display("FAIL z_unexpected_output: got %b expected none at %0t", obs_z, $time);
      end else chk("z_cycle", obs_z, q_z.pop_front());
    end
    if (rst_n && (busy_d || done_d)) begin
      if (q_d.size() == 0) begin
        checks++; errors++;
        $display("FAIL d_unexpected_output: got %b expected none at %0t", obs_d, $time);
      end else chk("d_cycle", obs_d, q_d.pop_front());
    end
  end

  task automatic wait_ready(input bit which_d);
    int n = 0;
    while (((which_d ? rdy_d : rdy_z) !== 1'b1) && n < 200) begin
      @(posedge clk); #1; n++;
    end
    chk(which_d ? "d_ready_wait" : "z_ready_wait", {7'd0, which_d ? rdy_d : rdy_z}, 8'd1);
  endtask

  function automatic logic [3:0] rr_rows(input bit rr, input logic [3:0] fixed, input int i);
    return rr ? (4'b0001 << (i % 4)) : fixed;
  endfunction

  task automatic run_z(input logic [3:0] key, input int hold, input bit rr, input logic [3:0] fixed);
    int n;
    n = ((hold == 0) ? 1 : hold) + 4;
    @(posedge clk); #1;
    wait_ready(1'b0);
    for (int i = 0; i <= n; i++) q_z.push_back(exp_rec(0, 4, key, hold, 8'h00, rr_rows(rr, fixed, i), i));
    key_z = key; hold_z = 8'(hold); val_z = 1'b1;
    @(posedge clk); #1;
    val_z = 1'b0; key_z = ~key; hold_z = 8'hFF;
    for (int i = 0; i <= n; i++) begin
      rows_z = rr_rows(rr, fixed, i);
      @(posedge clk); #1;
    end
  endtask

  task automatic run_d(input logic [3:0] key, input int hold, input logic [3:0] rows);
    int n;
    logic [7:0] lf;
    n = 2 * 8 + ((hold == 0) ? 1 : hold) + 16;
    wait_ready(1'b1);
    lf = lf_m;
    for (int i = 0; i <= n; i++) begin
      lf = lf_step(lf);
      q_d.push_back(exp_rec(8, 16, key, hold, lf, rows, i));
    end
    rows_d = rows; key_d = key; hold_d = 8'(hold); val_d = 1'b1;
    @(posedge clk); #1;
    val_d = 1'b0; key_d = ~key; hold_d = 8'h00;
    repeat (n + 1) begin @(posedge clk); #1; end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [7:0] lf;
    rst_n = 1'b0;
    val_z = 1'b0; key_z = '0; hold_z = '0; rows_z = 4'b1111;
    val_d = 1'b0; key_d = '0; hold_d = '0; rows_d = 4'b1111;
    #12;
    chk("z_in_reset", obs_z & 8'h7F, 8'h00);
    chk("d_in_reset", obs_d & 8'h7F, 8'h00);
    #10 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("z_after_reset", obs_z, 8'b1000_0000);
    chk("d_after_reset", obs_d, 8'b1000_0000);

    run_z(4'h5, 10, 1'b1, 4'b0000);
    run_z(4'h0, 0, 1'b0, 4'b1000);

    run_d(4'hD, 20, 4'b1000);

    // Back-to-back with cmd_valid held: key 9 must be taken on key 1's done cycle.
    wait_ready(1'b1);
    n  = 2 * 8 + 3 + 16;
    lf = lf_m;
    for (int i = 0; i <= n; i++) begin lf = lf_step(lf); q_d.push_back(exp_rec(8, 16, 4'h1, 3, lf, 4'b0101, i)); end
    for (int i = 0; i <= n; i++) begin lf = lf_step(lf); q_d.push_back(exp_rec(8, 16, 4'h9, 3, lf, 4'b0101, i)); end
    rows_d = 4'b0101; key_d = 4'h1; hold_d = 8'd3; val_d = 1'b1;
    @(posedge clk); #1;
    key_d = 4'h9;
    repeat (n + 1) begin @(posedge clk); #1; end
    val_d = 1'b0;
    repeat (n + 1) begin @(posedge clk); #1; end

    // Reset in the middle of HELD for key A.
    wait_ready(1'b1);
    lf = lf_m;
    for (int i = 0; i < 13; i++) begin lf = lf_step(lf); q_d.push_back(exp_rec(8, 16, 4'hA, 20, lf, 4'b0001, i)); end
    rows_d = 4'b0001; key_d = 4'hA; hold_d = 8'd20; val_d = 1'b1;
    @(posedge clk); #1;
    val_d = 1'b0;
    repeat (13) @(posedge clk);
    #1;
    chk("d_held_before_reset", obs_d, 8'b0101_1000);
    #1 rst_n = 1'b0;
    #1;
    chk("d_async_reset", obs_d & 8'h7F, 8'h00);
    chk("d_queue_at_abort", 8'(q_d.size()), 8'd0);
    @(posedge clk); @(posedge clk); #3;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("d_idle_after_reset", obs_d, 8'b1000_0000);
    run_d(4'h7, 5, 4'b0100);

    repeat (3) @(posedge clk);
    chk("z_queue_drained", 8'(q_z.size()), 8'd0);
    chk("d_queue_drained", 8'(q_d.size()), 8'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
